pacman_motion: RTL and testbench

Pac-Man position and orientation controller. Once per video frame it takes the latest joystick direction request and checks candidate moves against the maze through a wall-query handshake. It then commits the new top-left sprite coordinate and the flip pair that the sprite renderer consumes. It sits between input/maze logic and the sprite renderer, and is the only writer of the renderer's position and orientation inputs.

---
 rtl/pacman_pkg.sv | 68 ++++++
 rtl/pacman_motion.sv | 196 +++++++++++++++++++
 tb/tb_pacman_motion.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared Pac-Man motion types: headings, renderer flip mapping, move candidates.
// Latency: pure combinational helpers, no state.
// Backpressure: not applicable; shared by the motion, renderer and maze blocks.
package pacman_pkg;

    localparam int MAZE_W_DEF      = 224;
    localparam int MAZE_H_DEF      = 288;
    localparam int SPRITE_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PROBE_NEW = 2'd1,
        S_PROBE_CUR = 2'd2,
        S_COMMIT    = 2'd3
    } motion_state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic       blocked;   // outside the vertical playfield, never queried
    } cand_t;

    // Renderer orientation pair {h_flip, v_flip} for a heading.
    function automatic logic [1:0] flip_map(input dir_t d);
        logic [1:0] f;
        case (d)
            DIR_RIGHT: f = 2'b11;
            DIR_LEFT:  f = 2'b01;
            DIR_UP:    f = 2'b00;
            default:   f = 2'b10;
        endcase
        return f;
    endfunction

    // One-pixel step with horizontal tunnel wrap; vertical overrun is flagged.
    // Signed 10-bit arithmetic so that a step above row 0 shows up as negative.
    function automatic cand_t move_cand(input logic [8:0] x, input logic [8:0] y,
                                        input dir_t d, input int maze_w,
                                        input int maze_h, input int sprite);
        logic signed [9:0] cx;
        logic signed [9:0] cy;
        logic signed [9:0] x_max;
        logic signed [9:0] y_max;
        cand_t             c;
        cx    = signed'({1'b0, x});
        cy    = signed'({1'b0, y});
        x_max = 10'(maze_w - sprite);
        y_max = 10'(maze_h - sprite);
        case (d)
            DIR_RIGHT: cx = (cx == x_max) ? 10'sd0 : cx + 10'sd1;
            DIR_LEFT:  cx = (cx == 10'sd0) ? x_max : cx - 10'sd1;
            DIR_UP:    cy = cy - 10'sd1;
            default:   cy = cy + 10'sd1;
        endcase
        c.x       = cx[8:0];
        c.y       = cy[8:0];
        c.blocked = (cy < 10'sd0) || (cy > y_max);
        return c;
    endfunction

endpackage

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man movement: buffered turn probe, straight-ahead probe, commit.
// Latency: 5 cycles frame_start-to-commit with one wall query, more per extra query.
// Backpressure: wall_req held until wall_ack; frame_start ignored while busy.
module pacman_motion
    import pacman_pkg::*;
#(
    parameter int MAZE_W          = MAZE_W_DEF,
    parameter int MAZE_H          = MAZE_H_DEF,
    parameter int SPRITE_SIZE     = SPRITE_SIZE_DEF,
    parameter int START_X         = 108,
    parameter int START_Y         = 208,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    output logic       wall_req,
    output logic [8:0] wall_x,
    output logic [8:0] wall_y,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [8:0] x_pac,
    output logic [8:0] y_pac,
    output logic       h_flip,
    output logic       v_flip,
    output logic       moving,
    output logic       busy
);

    localparam int           CW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    motion_state_t state_q, state_d;
    dir_t          cur_dir_q, cur_dir_d;
    dir_t          pend_dir_q, pend_dir_d;
    dir_t          qry_dir_q, qry_dir_d;     // heading of the query in flight
    logic          pend_valid_q, pend_valid_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [8:0]    x_q, x_d, y_q, y_d;
    logic          h_flip_q, h_flip_d, v_flip_q, v_flip_d;
    logic          moving_q, moving_d;
    logic          adv_q, adv_d;
    logic          wall_req_q, wall_req_d;
    logic [8:0]    wall_x_q, wall_x_d, wall_y_q, wall_y_d;
    logic          busy_q, busy_d;

    dir_t          probe_dir;
    cand_t         cand;

    assign probe_dir = (state_q == S_PROBE_NEW) ? pend_dir_q : cur_dir_q;
    assign cand      = move_cand(x_q, y_q, probe_dir, MAZE_W, MAZE_H, SPRITE_SIZE);

    // Next-state and registered-output logic for the probe/commit sequence.
    always_comb begin
        state_d      = state_q;
        cur_dir_d    = cur_dir_q;
        pend_dir_d   = pend_dir_q;
        qry_dir_d    = qry_dir_q;
        pend_valid_d = pend_valid_q;
        frame_cnt_d  = frame_cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        h_flip_d     = h_flip_q;
        v_flip_d     = v_flip_q;
        moving_d     = moving_q;
        adv_d        = adv_q;
        wall_req_d   = wall_req_q;
        wall_x_d     = wall_x_q;
        wall_y_d     = wall_y_q;

        case (state_q)
            S_IDLE: begin
                adv_d = 1'b0;
                if (frame_start) begin
                    if (frame_cnt_q == LAST) begin
                        frame_cnt_d = '0;
                        state_d     = S_PROBE_NEW;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_PROBE_NEW: begin
                if (!wall_req_q) begin
                    if (!pend_valid_q || pend_dir_q == cur_dir_q || cand.blocked) begin
                        state_d = S_PROBE_CUR;
                    end else begin
                        wall_req_d = 1'b1;
                        wall_x_d   = cand.x;
                        wall_y_d   = cand.y;
                        qry_dir_d  = pend_dir_q;
                    end
                end else if (wall_ack) begin
                    wall_req_d = 1'b0;
                    if (!wall_hit) begin
                        cur_dir_d = qry_dir_q;
                        // A newer request that arrived mid-query stays pending.
                        if (pend_dir_q == qry_dir_q) begin
                            pend_valid_d = 1'b0;
                        end
                        adv_d   = 1'b1;
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_PROBE_CUR;
                    end
                end
            end
            S_PROBE_CUR: begin
                if (!wall_req_q) begin
                    if (cand.blocked) begin
                        adv_d   = 1'b0;
                        state_d = S_COMMIT;
                    end else begin
                        wall_req_d = 1'b1;
                        wall_x_d   = cand.x;
                        wall_y_d   = cand.y;
                        qry_dir_d  = cur_dir_q;
                    end
                end else if (wall_ack) begin
                    wall_req_d = 1'b0;
                    adv_d      = !wall_hit;
                    state_d    = S_COMMIT;
                end
            end
            default: begin
                if (adv_q) begin
                    x_d = wall_x_q;
                    y_d = wall_y_q;
                end
                {h_flip_d, v_flip_d} = flip_map(cur_dir_q);
                moving_d             = adv_q;
                state_d              = S_IDLE;
            end
        endcase

        // The most recent request always wins, even over a same-cycle clear.
        if (dir_valid) begin
            pend_dir_d   = dir_t'(dir_req);
            pend_valid_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cur_dir_q    <= DIR_LEFT;
            pend_dir_q   <= DIR_LEFT;
            qry_dir_q    <= DIR_LEFT;
            pend_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            x_q          <= 9'(START_X);
            y_q          <= 9'(START_Y);
            h_flip_q     <= 1'b0;
            v_flip_q     <= 1'b1;
            moving_q     <= 1'b0;
            adv_q        <= 1'b0;
            wall_req_q   <= 1'b0;
            wall_x_q     <= '0;
            wall_y_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_dir_q    <= cur_dir_d;
            pend_dir_q   <= pend_dir_d;
            qry_dir_q    <= qry_dir_d;
            pend_valid_q <= pend_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            h_flip_q     <= h_flip_d;
            v_flip_q     <= v_flip_d;
            moving_q     <= moving_d;
            adv_q        <= adv_d;
            wall_req_q   <= wall_req_d;
            wall_x_q     <= wall_x_d;
            wall_y_q     <= wall_y_d;
            busy_q       <= busy_d;
        end
    end

    assign wall_req = wall_req_q;
    assign wall_x   = wall_x_q;
    assign wall_y   = wall_y_q;
    assign x_pac    = x_q;
    assign y_pac    = y_q;
    assign h_flip   = h_flip_q;
    assign v_flip   = v_flip_q;
    assign moving   = moving_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion with a scripted wall-query responder.
// Latency: checks taken on the falling edge after each processed frame.
// Backpressure: responder ack delay is programmable per step.
module tb_pacman_motion;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic       wall_req;
    logic [8:0] wall_x;
    logic [8:0] wall_y;
    logic       wall_ack;
    logic       wall_hit;
    logic [8:0] x_pac;
    logic [8:0] y_pac;
    logic       h_flip;
    logic       v_flip;
    logic       moving;
    logic       busy;

    int n_asserts = 0;
    int n_fail    = 0;

    int resp_dly  = 0;
    int late_ack  = 0;
    int hits[$];
    int qx[$];
    int qy[$];

    pacman_motion dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .dir_valid  (dir_valid),
        .dir_req    (dir_req),
        .wall_req   (wall_req),
        .wall_x     (wall_x),
        .wall_y     (wall_y),
        .wall_ack   (wall_ack),
        .wall_hit   (wall_hit),
        .x_pac      (x_pac),
        .y_pac      (y_pac),
        .h_flip     (h_flip),
        .v_flip     (v_flip),
        .moving     (moving),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Maze responder: acks after resp_dly falling edges, logs each answered query.
    initial begin : responder
        int cnt;
        cnt      = 0;
        wall_ack = 1'b0;
        wall_hit = 1'b0;
        forever begin
            @(negedge clk);
            wall_ack = 1'b0;
            wall_hit = 1'b0;
            if (late_ack != 0) begin
                wall_ack = 1'b1;
            end else if (wall_req) begin
                if (cnt >= resp_dly) begin
                    wall_ack = 1'b1;
                    wall_hit = (hits.size() > 0) ? 1'(hits.pop_front()) : 1'b0;
                    qx.push_back(int'(wall_x));
                    qy.push_back(int'(wall_y));
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [1:0] d);
        @(negedge clk);
        dir_valid = 1'b1;
        dir_req   = d;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    // One frame pulse, then wait (bounded) for the commit to finish.
    task automatic do_frame(input string tag);
        int n;
        qx.delete();
        qy.delete();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, int'(busy), 0);
    endtask

    initial begin
        int k;
        rst         = 1'b0;
        frame_start = 1'b0;
        dir_valid   = 1'b0;
        dir_req     = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_x", int'(x_pac), 108);
        chk("rst_y", int'(y_pac), 208);
        chk("rst_h", int'(h_flip), 0);
        chk("rst_v", int'(v_flip), 1);
        chk("rst_req", int'(wall_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mov", int'(moving), 0);

        // No request, slow ack: straight on LEFT
        resp_dly = 3;
        do_frame("f1");
        chk("f1_nq", qx.size(), 1);
        chk("f1_qx", qx[0], 107);
        chk("f1_qy", qy[0], 208);
        chk("f1_x", int'(x_pac), 107);
        chk("f1_mov", int'(moving), 1);
        resp_dly = 0;

        // Turn UP
        request(2'd2);
        do_frame("up");
        chk("up_nq", qx.size(), 1);
        chk("up_qx", qx[0], 107);
        chk("up_qy", qy[0], 207);
        chk("up_y", int'(y_pac), 207);
        chk("up_h", int'(h_flip), 0);
        chk("up_v", int'(v_flip), 0);

        // Turn LEFT so the pre-turn case runs along x
        request(2'd1);
        do_frame("lf");
        chk("lf_x", int'(x_pac), 106);
        chk("lf_v", int'(v_flip), 1);

        // DOWN into a wall, LEFT still open
        hits.push_back(1);
        hits.push_back(0);
        request(2'd3);
        do_frame("dn1");
        chk("dn1_nq", qx.size(), 2);
        chk("dn1_q0y", qy[0], 208);
        chk("dn1_q1x", qx[1], 105);
        chk("dn1_x", int'(x_pac), 105);
        chk("dn1_y", int'(y_pac), 207);
        chk("dn1_h", int'(h_flip), 0);

        // Buffered DOWN taken with no fresh request
        do_frame("dn2");
        chk("dn2_nq", qx.size(), 1);
        chk("dn2_y", int'(y_pac), 208);
        chk("dn2_x", int'(x_pac), 105);
        chk("dn2_h", int'(h_flip), 1);
        chk("dn2_v", int'(v_flip), 0);

        // Walk LEFT to column 0, then wrap
        request(2'd1);
        k = 0;
        while (x_pac != 9'd0 && k < 200) begin
            do_frame("wl");
            k++;
        end
        chk("wl_steps", k, 105);
        do_frame("wrapl");
        chk("wrapl_qx", qx[0], 216);
        chk("wrapl_x", int'(x_pac), 216);
        request(2'd0);
        do_frame("wrapr");
        chk("wrapr_qx", qx[0], 0);
        chk("wrapr_x", int'(x_pac), 0);
        chk("wrapr_h", int'(h_flip), 1);
        chk("wrapr_v", int'(v_flip), 1);

        // Walk UP to row 0, then the top edge blocks without a query
        request(2'd2);
        k = 0;
        while (y_pac != 9'd0 && k < 300) begin
            do_frame("wu");
            k++;
        end
        chk("wu_steps", k, 208);
        do_frame("top");
        chk("top_nq", qx.size(), 0);
        chk("top_y", int'(y_pac), 0);
        chk("top_mov", int'(moving), 0);

        // Extra frame_start pulses during a 20-cycle query are ignored
        resp_dly = 20;
        request(2'd0);
        qx.delete();
        qy.delete();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ign_done", int'(busy), 0);
        k = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) k++;
        end
        chk("ign_extra", k, 0);
        chk("ign_nq", qx.size(), 1);
        chk("ign_x", int'(x_pac), 1);
        chk("ign_h", int'(h_flip), 1);

        // Reset in the middle of a query
        resp_dly = 1000;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        k = 0;
        while (!wall_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mq_req", int'(wall_req), 1);
        rst = 1'b0;
        #1;
        chk("mq_req0", int'(wall_req), 0);
        chk("mq_x", int'(x_pac), 108);
        chk("mq_y", int'(y_pac), 208);
        chk("mq_h", int'(h_flip), 0);
        chk("mq_v", int'(v_flip), 1);
        chk("mq_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        late_ack = 1;
        repeat (3) @(negedge clk);
        late_ack = 0;
        @(negedge clk);
        chk("late_busy", int'(busy), 0);
        chk("late_x", int'(x_pac), 108);
        chk("late_req", int'(wall_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
